traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_light_ctrl.sv | 98 +++++++++
 tb/tb_traffic_light_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Six-phase highway / farm-road traffic light controller.
// Highway rests on green; the farm road is served only while it has cars
// queued, bounded by minimum/maximum green dwell, yellow and all-red clearance.
module traffic_light_ctrl #(
    parameter int unsigned MIN_HW_GREEN = 8,
    parameter int unsigned MIN_FR_GREEN = 4,
    parameter int unsigned MAX_FR_GREEN = 12,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned ALL_RED_TIME = 1
) (
    input  logic       traffic_clk,
    input  logic       reset,
    input  logic       fr_car_in_queue,
    input  logic       hw_car_in_queue,
    output logic       HighWay_Green,
    output logic       HighWay_Yellow,
    output logic       HighWay_Red,
    output logic       FarmRoad_Green,
    output logic       FarmRoad_Yellow,
    output logic       FarmRoad_Red,
    output logic [2:0] phase,
    output logic       fr_go
);

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        RED_TO_FR = 3'd2,
        FR_GREEN  = 3'd3,
        FR_YELLOW = 3'd4,
        RED_TO_HW = 3'd5
    } state_t;

    // Dwell limits widened to match the 9-bit elapsed count.
    localparam logic [8:0] MIN_HW = 9'(MIN_HW_GREEN);
    localparam logic [8:0] MIN_FR = 9'(MIN_FR_GREEN);
    localparam logic [8:0] MAX_FR = 9'(MAX_FR_GREEN);
    localparam logic [8:0] YEL    = 9'(YELLOW_TIME);
    localparam logic [8:0] ALLRED = 9'(ALL_RED_TIME);

    state_t     state, state_nxt;
    logic [7:0] timer;
    logic [8:0] elapsed;

    // Cycles already spent in the current state, including this one;
    // one bit wider so a saturated timer cannot wrap.
    assign elapsed = {1'b0, timer} + 9'd1;

    // Next-state selection from dwell time and queue status.
    always_comb begin
        state_nxt = state;
        case (state)
            HW_GREEN:  if (elapsed >= MIN_HW && fr_car_in_queue) state_nxt = HW_YELLOW;
            HW_YELLOW: if (elapsed == YEL)    state_nxt = RED_TO_FR;
            RED_TO_FR: if (elapsed == ALLRED) state_nxt = FR_GREEN;
            FR_GREEN:  if (elapsed >= MIN_FR &&
                           (!fr_car_in_queue || (elapsed >= MAX_FR && hw_car_in_queue)))
                           state_nxt = FR_YELLOW;
            FR_YELLOW: if (elapsed == YEL)    state_nxt = RED_TO_HW;
            RED_TO_HW: if (elapsed == ALLRED) state_nxt = HW_GREEN;
            default:   state_nxt = HW_GREEN;  // codes 6/7 recover to highway green
        endcase
    end

    // State, dwell timer (cleared on every state change, saturating) and fr_go pulse.
    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            state <= HW_GREEN;
            timer <= 8'd0;
            fr_go <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  timer <= 8'd0;
            else if (timer != 8'hFF) timer <= timer + 8'd1;
            fr_go <= (state == RED_TO_FR) && (state_nxt == FR_GREEN);
        end
    end

    // Lamp decode: one lamp per road, red whenever that road is not being served.
    always_comb begin
        HighWay_Green   = 1'b0;
        HighWay_Yellow  = 1'b0;
        HighWay_Red     = 1'b1;
        FarmRoad_Green  = 1'b0;
        FarmRoad_Yellow = 1'b0;
        FarmRoad_Red    = 1'b1;
        case (state)
            HW_GREEN:  begin HighWay_Green   = 1'b1; HighWay_Red  = 1'b0; end
            HW_YELLOW: begin HighWay_Yellow  = 1'b1; HighWay_Red  = 1'b0; end
            FR_GREEN:  begin FarmRoad_Green  = 1'b1; FarmRoad_Red = 1'b0; end
            FR_YELLOW: begin FarmRoad_Yellow = 1'b1; FarmRoad_Red = 1'b0; end
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed phase-length checks plus randomized
// queue traffic, all compared every cycle against a phase/dwell-count model.
module tb_traffic_light_ctrl;

    localparam int MIN_HW  = 8;
    localparam int MIN_FR  = 4;
    localparam int MAX_FR  = 12;
    localparam int YEL     = 3;
    localparam int ALLRED  = 1;

    logic       clk = 1'b0;
    logic       reset, fr, hw;
    logic       hg, hy, hr, fg, fy, frd;
    logic [2:0] phase;
    logic       fr_go;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .MIN_HW_GREEN(MIN_HW), .MIN_FR_GREEN(MIN_FR), .MAX_FR_GREEN(MAX_FR),
        .YELLOW_TIME(YEL), .ALL_RED_TIME(ALLRED)
    ) dut (
        .traffic_clk(clk), .reset(reset),
        .fr_car_in_queue(fr), .hw_car_in_queue(hw),
        .HighWay_Green(hg), .HighWay_Yellow(hy), .HighWay_Red(hr),
        .FarmRoad_Green(fg), .FarmRoad_Yellow(fy), .FarmRoad_Red(frd),
        .phase(phase), .fr_go(fr_go)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase number, cycles spent in it, and the entry pulse.
    // Lamp per phase: 0 green, 1 yellow, 2 red.
    int m_phase = 0;
    int m_cnt   = 1;
    bit m_go    = 0;
    bit m_valid = 0;
    int hw_lamp [6] = '{0, 1, 2, 2, 2, 2};
    int fr_lamp [6] = '{2, 2, 2, 0, 1, 2};

    // Model advance on each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        bit leave;
        int exp_t;
        leave = 0;
        if (reset) begin
            m_phase = 0; m_cnt = 1; m_go = 0; m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                0:       leave = (m_cnt >= MIN_HW) && fr;
                1, 4:    leave = (m_cnt == YEL);
                2, 5:    leave = (m_cnt == ALLRED);
                default: leave = (m_cnt >= MIN_FR) && (!fr || (m_cnt >= MAX_FR && hw));
            endcase
            if (leave) begin
                m_phase = (m_phase + 1) % 6;
                m_cnt   = 1;
                m_go    = (m_phase == 3);
            end else begin
                m_cnt++;
                m_go = 0;
            end
        end
        #1;
        if (m_valid) begin
            exp_t = (m_cnt - 1 > 255) ? 255 : m_cnt - 1;
            chk("phase",   int'(phase), m_phase);
            chk("fr_go",   int'(fr_go), int'(m_go));
            chk("timer",   int'(dut.timer), exp_t);
            chk("hw_green",  int'(hg),  int'(hw_lamp[m_phase] == 0));
            chk("hw_yellow", int'(hy),  int'(hw_lamp[m_phase] == 1));
            chk("hw_red",    int'(hr),  int'(hw_lamp[m_phase] == 2));
            chk("fr_green",  int'(fg),  int'(fr_lamp[m_phase] == 0));
            chk("fr_yellow", int'(fy),  int'(fr_lamp[m_phase] == 1));
            chk("fr_red",    int'(frd), int'(fr_lamp[m_phase] == 2));
            chk("hw_one_lamp", int'(hg) + int'(hy) + int'(hr), 1);
            chk("fr_one_lamp", int'(fg) + int'(fy) + int'(frd), 1);
            chk("no_dual_green", int'(hg & fg), 0);
        end
    end

    // Count consecutive negedges showing phase p, starting at the current one.
    task automatic run_len(input int p, output int n);
        n = 0;
        while (int'(phase) == p && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (int'(phase) != p && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("wait_phase%0d", p), int'(phase), p);
    endtask

    int n;

    initial begin
        reset = 1'b1; fr = 1'b0; hw = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_phase", int'(phase), 0);
        chk("rst_hw_green", int'(hg), 1);
        chk("rst_fr_red", int'(frd), 1);
        chk("rst_fr_go", int'(fr_go), 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_phase", int'(phase), 0);

        // Farm request right after reset: 8 / 3 / 1 then farm green.
        reset = 1'b1; @(negedge clk);
        reset = 1'b0; fr = 1'b1;
        run_len(0, n); chk("len_hw_green", n, 8);
        run_len(1, n); chk("len_hw_yellow", n, 3);
        run_len(2, n); chk("len_red_to_fr", n, 1);
        chk("enter_fr_green", int'(phase), 3);
        chk("fr_go_first", int'(fr_go), 1);
        @(negedge clk);
        chk("fr_go_second", int'(fr_go), 0);
        fr = 1'b0;                        // drop at elapsed 2
        run_len(3, n); chk("len_fr_green_min", n + 1, 4);
        run_len(4, n); chk("len_fr_yellow", n, 3);
        run_len(5, n); chk("len_red_to_hw", n, 1);
        chk("back_hw_green", int'(phase), 0);

        // Both queues busy: farm green capped at MAX_FR.
        fr = 1'b1; hw = 1'b1;
        run_len(0, n); chk("len_hw_green2", n, 8);
        run_len(1, n);
        run_len(2, n);
        run_len(3, n); chk("len_fr_green_max", n, 12);
        hw = 1'b0;
        run_len(4, n);
        run_len(5, n);
        wait_phase(3);

        // No highway traffic: farm green holds well past MAX_FR.
        n = 0;
        repeat (35) begin
            if (int'(phase) == 3) n++;
            @(negedge clk);
        end
        chk("fr_hold", n, 35);
        hw = 1'b1;
        @(negedge clk);
        chk("fr_hold_release", int'(phase), 4);

        // Reset mid-phase in HW_YELLOW and in FR_GREEN.
        wait_phase(1);
        reset = 1'b1; @(negedge clk);
        chk("rst_in_yellow_phase", int'(phase), 0);
        chk("rst_in_yellow_timer", int'(dut.timer), 0);
        reset = 1'b0;
        wait_phase(3);
        @(negedge clk);
        reset = 1'b1; @(negedge clk);
        chk("rst_in_frg_phase", int'(phase), 0);
        chk("rst_in_frg_timer", int'(dut.timer), 0);
        chk("rst_in_frg_fr_red", int'(frd), 1);
        reset = 1'b0;

        // Randomized traffic; segment 0 keeps the farm road empty long enough to saturate the timer.
        for (int seg = 0; seg < 10; seg++) begin
            repeat (400) begin
                reset = ($urandom_range(0, 299) == 0);
                case (seg % 3)
                    0:       fr = (seg == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
                    1:       fr = ($urandom_range(0, 9) != 0);
                    default: if ($urandom_range(0, 19) == 0) fr = ~fr;
                endcase
                if ($urandom_range(0, 14) == 0) hw = ~hw;
                @(negedge clk);
            end
        end
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
